// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell and a borrow flop,
// iterated W times behind a start/busy/done handshake.
module serial_subtractor #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         borrow
);

   // state | meaning
   // IDLE  | waiting for start; operands captured on accepted start
   // RUN   | one difference bit per clock, LSB first, W clocks
   // DONE  | one-cycle done pulse; diff/borrow freshly valid
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(W);

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    sa;
   logic [W-1:0]    sb;
   logic            br;
   logic [CW-1:0]   count;
   logic            bit0;
   logic            br_nxt;
   logic            last;
   logic [W-1:0]    sa_shift;

   assign bit0     = sa[0] ^ sb[0] ^ br;
   assign br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign last     = (count == CW'(W - 1));
   // The minuend register doubles as the partial-result shifter: each consumed
   // LSB slot is refilled at the MSB with the new difference bit.
   assign sa_shift = {bit0, sa[W-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         br     <= 1'b0;
         count  <= '0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  count <= '0;
               end
            end
            RUN: begin
               sa <= sa_shift;
               sb <= {1'b0, sb[W-1:1]};
               br <= br_nxt;
               if (last) begin
                  diff   <= sa_shift;
                  borrow <= br_nxt;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): directed ops plus an
// exhaustive sweep, results checked against a queue of expected values.
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   logic [W:0] exp_q[$];

   serial_subtractor #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every done pulse pops one expected {borrow, diff}.
   always @(negedge clk) begin
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("diff", diff, e[W-1:0]);
            chk("borrow", borrow, e[W]);
         end
      end
   end

   // Wait for idle at a falling edge, then present the op for the next rising edge.
   task automatic issue(input int av, input int bv);
      int n;
      logic [W-1:0] ed;
      n = 0;
      @(negedge clk);
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("issue_timeout", 1, 0);
      a = W'(av);
      b = W'(bv);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ed = W'(av - bv);
      exp_q.push_back({(av < bv) ? 1'b1 : 1'b0, ed});
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      int busy_n;
      int done_at;
      int d0;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      @(negedge clk);
      rst = 1'b0;

      // T1: latency and busy length
      issue(5, 3);
      busy_n  = 0;
      done_at = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done && done_at == 0) done_at = i;
      end
      chk("t1_busy_cycles", busy_n, 5);
      chk("t1_done_cycle", done_at, 5);
      chk("t1_diff_held", diff, 2);

      // T2 / T3
      issue(3, 5);
      issue(0, 1);
      issue(15, 15);
      issue(15, 0);
      drain();

      // T4: start while busy is ignored
      d0 = done_cnt;
      issue(9, 2);
      @(negedge clk);
      @(negedge clk);
      a = 4'd1;
      b = 4'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("t4_done_count", done_cnt - d0, 1);
      chk("t4_diff", diff, 7);
      chk("t4_busy_after", busy, 0);

      // T5: reset mid-RUN aborts without a done pulse
      d0 = done_cnt;
      @(negedge clk);
      a = 4'd12;
      b = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      chk("t5_diff", diff, 0);
      chk("t5_borrow", borrow, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("t5_no_done", done_cnt - d0, 0);
      issue(6, 4);
      drain();
      chk("t5_fresh_diff", diff, 2);

      // T6: exhaustive, back-to-back
      d0 = done_cnt;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            issue(i, j);
      drain();
      chk("t6_done_count", done_cnt - d0, 256);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
